// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between the execute stage and a word-wide single-port synchronous RAM.
// Sub-word stores are read-modify-write; loads are lane-extracted and sign/zero extended.
module lsu_mem_ctrl #(
  parameter int unsigned MEM_AW  = 10,
  parameter int unsigned RAM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_width_i,
  input  logic              req_unsigned_i,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              busy_o,
  output logic [MEM_AW-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i
);

  localparam int unsigned CntW = $clog2(RAM_LAT + 1) + 1;

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       word_q, word_d;
  logic              we_q;
  logic [1:0]        width_q;
  logic              uns_q;
  logic [1:0]        lane_q;
  logic              err_q;
  logic [31:0]       wdata_q;
  logic [MEM_AW-1:0] addr_q;

  logic              accept;
  logic              req_err;
  logic [31:0]       merged;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       load_v;

  // Address bits above the RAM word range wrap silently.
  logic unused_addr;
  assign unused_addr = ^req_addr_i[31:MEM_AW+2];

  assign accept  = req_valid_i && (state_q == StIdle);
  assign req_err = (req_width_i == 2'b11) ||
                   ((req_width_i == 2'b01) && req_addr_i[0]) ||
                   ((req_width_i == 2'b10) && (req_addr_i[1:0] != 2'b00));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      word_q  <= '0;
      we_q    <= 1'b0;
      width_q <= 2'b00;
      uns_q   <= 1'b0;
      lane_q  <= 2'b00;
      err_q   <= 1'b0;
      wdata_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      if (accept) begin
        we_q    <= req_we_i;
        width_q <= req_width_i;
        uns_q   <= req_unsigned_i;
        lane_q  <= req_addr_i[1:0];
        err_q   <= req_err;
        wdata_q <= req_wdata_i;
        addr_q  <= req_addr_i[MEM_AW+1:2];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (accept) begin
          if (req_err) begin
            state_d = StResp;
          end else if (req_we_i && (req_width_i == 2'b10)) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd: begin
        // Address is presented from the first RD cycle; data lands RAM_LAT cycles later.
        if (cnt_q == CntW'(RAM_LAT)) begin
          word_d  = ram_rdata_i;
          cnt_d   = '0;
          state_d = we_q ? StWr : StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWr:    state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    merged = word_q;
    unique case (width_q)
      2'b00:   merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  assign byte_v = word_q[{lane_q, 3'b000} +: 8];
  assign half_v = word_q[{lane_q[1], 4'b0000} +: 16];

  always_comb begin
    unique case (width_q)
      2'b00:   load_v = {{24{~uns_q & byte_v[7]}}, byte_v};
      2'b01:   load_v = {{16{~uns_q & half_v[15]}}, half_v};
      default: load_v = word_q;
    endcase
  end

  assign req_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_err_o   = (state_q == StResp) && err_q;
  assign rsp_rdata_o = ((state_q == StResp) && !we_q && !err_q) ? load_v : 32'h0;
  assign ram_we_o    = (state_q == StWr);
  assign ram_wdata_o = (state_q == StWr) ? merged : 32'h0;
  assign ram_addr_o  = addr_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: RAM model, transaction-level reference model, per-cycle compare,
// directed scenarios with literal expectations and a randomized phase.
module tb_lsu_mem_ctrl;

  localparam int unsigned AW  = 10;
  localparam int unsigned LAT = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_width = 2'b00;
  logic          req_unsigned = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          busy;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  int checks = 0;
  int failures = 0;

  lsu_mem_ctrl #(.MEM_AW(AW), .RAM_LAT(LAT)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_width_i    (req_width),
    .req_unsigned_i (req_unsigned),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err),
    .busy_o         (busy),
    .ram_addr_o     (ram_addr),
    .ram_we_o       (ram_we),
    .ram_wdata_o    (ram_wdata),
    .ram_rdata_i    (ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous read with LAT-cycle pipeline, write-first not needed.
  logic [31:0] ram_mem [2**AW];
  logic [31:0] rd_pipe [LAT];
  assign ram_rdata = rd_pipe[LAT-1];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    rd_pipe[0] <= ram_mem[ram_addr];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction, described by its latency, write cycle and results.
  logic [31:0] ref_mem [2**AW];
  int          m_n = 0;
  int          m_lat = 0;
  int          m_wecyc = 0;
  logic [AW-1:0] m_waddr = '0;
  logic [31:0] m_nw = '0;
  logic [31:0] m_rdata = '0;
  logic        m_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n = 0;
    end else if (m_n == 0) begin
      if (req_valid) begin
        logic [31:0] mask, old, v;
        int sh;
        m_err = (req_width == 2'd3) || (req_width == 2'd1 && req_addr[0]) ||
                (req_width == 2'd2 && req_addr[1:0] != 2'd0);
        m_waddr = req_addr[AW+1:2];
        mask = (req_width == 2'd0) ? 32'hFF : (req_width == 2'd1) ? 32'hFFFF : 32'hFFFFFFFF;
        sh = 8 * int'(req_addr[1:0]);
        old = ref_mem[m_waddr];
        m_nw = (old & ~(mask << sh)) | ((req_wdata & mask) << sh);
        v = (old >> sh) & mask;
        if (!req_unsigned && ((v & ((mask >> 1) + 1)) != 0)) v = v | ~mask;
        m_rdata = (m_err || req_we) ? 32'h0 : v;
        if (m_err) begin
          m_lat = 1; m_wecyc = 0;
        end else if (req_we && req_width == 2'd2) begin
          m_lat = 2; m_wecyc = 1;
        end else if (req_we) begin
          m_lat = 3 + LAT; m_wecyc = 2 + LAT;
        end else begin
          m_lat = 2 + LAT; m_wecyc = 0;
        end
        m_n = 1;
      end
    end else begin
      if (m_n == m_wecyc) ref_mem[m_waddr] = m_nw;
      if (m_n == m_lat) m_n = 0;
      else m_n++;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
      chk("rst_ram_we", {31'b0, ram_we}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_ram_addr", {{(32-AW){1'b0}}, ram_addr}, 32'd0);
      chk("rst_ram_wdata", ram_wdata, 32'd0);
    end else begin
      chk("busy", {31'b0, busy}, {31'b0, m_n != 0});
      chk("req_ready", {31'b0, req_ready}, {31'b0, m_n == 0});
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_n != 0 && m_n == m_lat});
      chk("ram_we", {31'b0, ram_we}, {31'b0, m_n != 0 && m_n == m_wecyc});
      if (m_n != 0) chk("ram_addr", {{(32-AW){1'b0}}, ram_addr}, {{(32-AW){1'b0}}, m_waddr});
      if (m_n != 0 && m_n == m_lat) begin
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, m_err});
      end
      if (m_n != 0 && m_n == m_wecyc) chk("ram_wdata", ram_wdata, m_nw);
    end
  end

  // Issue one request from idle and record when/what the DUT produced.
  task automatic run_req(input logic we, input logic [1:0] w, input logic u,
                         input logic [31:0] a, input logic [31:0] d,
                         output int we_n, output int rsp_n, output logic [31:0] wd,
                         output logic [31:0] wa, output logic [31:0] rd, output logic er);
    we_n = 0; rsp_n = 0; wd = '0; wa = '0; rd = '0; er = 1'b0;
    @(posedge clk); #2;
    req_valid = 1'b1; req_we = we; req_width = w; req_unsigned = u;
    req_addr = a; req_wdata = d;
    @(posedge clk); #2;
    req_valid = 1'b0;
    for (int n = 1; n <= 20 && rsp_n == 0; n++) begin
      @(negedge clk);
      if (ram_we && we_n == 0) begin
        we_n = n; wd = ram_wdata; wa = {{(32-AW){1'b0}}, ram_addr};
      end
      if (rsp_valid) begin
        rsp_n = n; rd = rsp_rdata; er = rsp_err;
      end
    end
  endtask

  int          we_n, rsp_n;
  logic [31:0] wd, wa, rd;
  logic        er;

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      ram_mem[i] = $urandom;
      ref_mem[i] = ram_mem[i];
    end
    for (int i = 0; i < LAT; i++) rd_pipe[i] = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // SW 0x10
    run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, we_n, rsp_n, wd, wa, rd, er);
    chk("t1_we_cycle", we_n, 1);
    chk("t1_ram_addr", wa, 32'd4);
    chk("t1_wdata", wd, 32'hDEADBEEF);
    chk("t1_rsp_cycle", rsp_n, 2);
    chk("t1_err", {31'b0, er}, 32'd0);

    // SB 0x11
    run_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000A5, we_n, rsp_n, wd, wa, rd, er);
    chk("t2_we_cycle", we_n, 3);
    chk("t2_wdata", wd, 32'hDEADA5EF);
    chk("t2_rsp_cycle", rsp_n, 4);

    // Loads from word4
    run_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, we_n, rsp_n, wd, wa, rd, er);
    chk("t3_lb", rd, 32'hFFFFFFDE);
    chk("t3_lb_cycle", rsp_n, 3);
    chk("t3_lb_no_we", we_n, 0);
    run_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, we_n, rsp_n, wd, wa, rd, er);
    chk("t3_lbu", rd, 32'h000000DE);
    run_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, we_n, rsp_n, wd, wa, rd, er);
    chk("t3_lh", rd, 32'hFFFFDEAD);
    chk("t3_lh_cycle", rsp_n, 3);

    // Errors
    run_req(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, we_n, rsp_n, wd, wa, rd, er);
    chk("t4_lw_cycle", rsp_n, 1);
    chk("t4_lw_err", {31'b0, er}, 32'd1);
    chk("t4_lw_rdata", rd, 32'd0);
    run_req(1'b1, 2'd1, 1'b0, 32'h11, 32'h1234, we_n, rsp_n, wd, wa, rd, er);
    chk("t4_sh_cycle", rsp_n, 1);
    chk("t4_sh_err", {31'b0, er}, 32'd1);
    chk("t4_sh_no_we", we_n, 0);
    run_req(1'b1, 2'd3, 1'b0, 32'h10, 32'h55, we_n, rsp_n, wd, wa, rd, er);
    chk("t4_w11_err", {31'b0, er}, 32'd1);
    chk("t4_w11_no_we", we_n, 0);
    chk("t4_word4", ram_mem[4], 32'hDEADA5EF);

    // Reset during RD of a sub-word store
    begin
      int seen_we, seen_rsp;
      seen_we = 0; seen_rsp = 0;
      @(posedge clk); #2;
      req_valid = 1'b1; req_we = 1'b1; req_width = 2'd0; req_addr = 32'h12; req_wdata = 32'h77;
      @(posedge clk); #2;
      req_valid = 1'b0;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      for (int n = 0; n < 6; n++) begin
        @(negedge clk);
        if (n == 0) chk("t5_ready", {31'b0, req_ready}, 32'd1);
        if (ram_we) seen_we++;
        if (rsp_valid) seen_rsp++;
      end
      chk("t5_no_we", seen_we, 0);
      chk("t5_no_rsp", seen_rsp, 0);
      chk("t5_word4", ram_mem[4], 32'hDEADA5EF);
    end

    // Back-to-back with req_valid held high
    begin
      int ready_n;
      ready_n = 0;
      @(posedge clk); #2;
      req_valid = 1'b1; req_we = 1'b1; req_width = 2'd2; req_addr = 32'h20;
      req_wdata = 32'h11223344;
      @(posedge clk); #2;
      req_width = 2'd0; req_addr = 32'h21; req_wdata = 32'h000000AB;
      for (int n = 1; n <= 10 && ready_n == 0; n++) begin
        @(negedge clk);
        if (req_ready) ready_n = n;
      end
      chk("t6_second_accept", ready_n, 3);
      @(posedge clk); #2;
      req_valid = 1'b0;
      repeat (8) @(negedge clk);
      chk("t6_word8_ram", ram_mem[8], 32'h1122AB44);
      chk("t6_word8_model", ref_mem[8], 32'h1122AB44);
    end

    // Randomized traffic, occasional reset
    for (int it = 0; it < 1500; it++) begin
      int r;
      @(posedge clk); #2;
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0; req_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
      end else begin
        req_valid = ($urandom % 4) != 0;
        req_we = $urandom % 2;
        r = $urandom % 8;
        req_width = (r < 3) ? 2'd0 : (r < 5) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
        req_unsigned = $urandom % 2;
        req_addr = (($urandom % 4) == 0) ? $urandom : ($urandom % 64);
        req_wdata = $urandom;
      end
    end
    @(posedge clk); #2;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    for (int i = 0; i < 2**AW; i++) chk("final_mem", ram_mem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
